// File: rtl/lsu_apb_master.sv
// Load/store unit to APB bridge: one request at a time, SETUP/ACCESS transfer,
// extended load data and error flag returned over a valid/ready response channel.
module lsu_apb_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [3:0]            pstb,
  input  logic                  pready,
  input  logic                  perr
);

  localparam int unsigned CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [1:0]              size_q, size_d;
  logic                    uns_q, uns_d;
  logic                    req_ready_d, rsp_valid_d, rsp_err_d;
  logic                    psel_d, penable_d, pwrite_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_d, pdata_d;
  logic [ADDR_WIDTH-1:0]   paddr_d;
  logic [3:0]              pstb_d;
  logic                    accept_c, illegal_c, done_c, tmo_c;

  function automatic logic [DATA_WIDTH-1:0] extend_load(input logic [DATA_WIDTH-1:0] d,
                                                        input logic [1:0] sz,
                                                        input logic uns);
    logic [DATA_WIDTH-1:0] r;
    case (sz)
      2'b00:   r = uns ? {{(DATA_WIDTH-8){1'b0}}, d[7:0]}
                       : {{(DATA_WIDTH-8){d[7]}}, d[7:0]};
      2'b01:   r = uns ? {{(DATA_WIDTH-16){1'b0}}, d[15:0]}
                       : {{(DATA_WIDTH-16){d[15]}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  assign accept_c  = (state_q == IDLE) && req_ready && req_valid;
  assign illegal_c = (req_size == 2'b11);
  assign done_c    = (state_q == ACCESS) && (pready || perr);
  // pready/perr in the last allowed cycle wins over the timeout
  assign tmo_c     = (TIMEOUT != 0) && (state_q == ACCESS) && !done_c &&
                     (cnt_q == CNT_W'(TMO_LAST));

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = illegal_c ? RESP : SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (done_c || tmo_c) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of every registered output, aligned with the next state
  always_comb begin
    req_ready_d = (state_d == IDLE);
    psel_d      = (state_d == SETUP) || (state_d == ACCESS);
    penable_d   = (state_d == ACCESS);
    rsp_valid_d = (state_d == RESP);
    cnt_d       = ((state_q == ACCESS) && (state_d == ACCESS)) ? cnt_q + CNT_W'(1) : '0;
    paddr_d     = paddr;
    pdata_d     = pdata;
    pwrite_d    = pwrite;
    pstb_d      = pstb;
    size_d      = size_q;
    uns_d       = uns_q;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;

    if (accept_c) begin
      if (illegal_c) begin
        rsp_err_d   = 1'b1;
        rsp_rdata_d = '0;
      end else begin
        paddr_d  = req_addr;
        pwrite_d = req_write;
        size_d   = req_size;
        uns_d    = req_unsigned;
        case (req_size)
          2'b00: begin
            pstb_d  = 4'b0001;
            pdata_d = {{(DATA_WIDTH-8){1'b0}}, req_wdata[7:0]};
          end
          2'b01: begin
            pstb_d  = 4'b0011;
            pdata_d = {{(DATA_WIDTH-16){1'b0}}, req_wdata[15:0]};
          end
          default: begin
            pstb_d  = 4'b1111;
            pdata_d = req_wdata;
          end
        endcase
      end
    end

    if (done_c) begin
      rsp_err_d   = perr;
      rsp_rdata_d = (perr || pwrite) ? '0 : extend_load(prdata, size_q, uns_q);
    end else if (tmo_c) begin
      rsp_err_d   = 1'b1;
      rsp_rdata_d = '0;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pdata     <= '0;
      pstb      <= '0;
      cnt_q     <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
    end else begin
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
      psel      <= psel_d;
      penable   <= penable_d;
      pwrite    <= pwrite_d;
      paddr     <= paddr_d;
      pdata     <= pdata_d;
      pstb      <= pstb_d;
      cnt_q     <= cnt_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
    end
  end

endmodule

// File: tb/tb_lsu_apb_master.sv
// Bench for lsu_apb_master: directed vector table, hand-written reset sequence,
// and random transactions scored against an arithmetic reference model.
module tb_lsu_apb_master;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 16;

  logic          pclk = 1'b0;
  logic          presetn;
  logic          req_valid, req_ready, req_write, req_unsigned;
  logic [AW-1:0] req_addr, paddr;
  logic [DW-1:0] req_wdata, rsp_rdata, pdata, prdata;
  logic [1:0]    req_size;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic          psel, penable, pwrite, pready, perr;
  logic [3:0]    pstb;

  always #5 pclk = ~pclk;

  lsu_apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_write(req_write), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .pdata(pdata), .prdata(prdata), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pstb(pstb), .pready(pready), .perr(perr)
  );

  int    errors = 0;
  int    checks = 0;
  string cur    = "init";

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    int          waits;
    logic [31:0] prd;
    logic        perr;
    logic        never;
    int          dly;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [3:0]  exp_stb;
    logic [31:0] exp_pd;
    int          exp_acc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %h expected %h", cur, name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] wdata, input logic wr,
                              input logic [1:0] size, input logic uns, input int waits,
                              input logic [31:0] prd, input logic pe, input logic never,
                              input int dly, input logic [31:0] exp_rd, input logic exp_err,
                              input logic [3:0] exp_stb, input logic [31:0] exp_pd,
                              input int exp_acc);
    vec_t v;
    v.addr = addr; v.wdata = wdata; v.wr = wr; v.size = size; v.uns = uns;
    v.waits = waits; v.prd = prd; v.perr = pe; v.never = never; v.dly = dly;
    v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_stb = exp_stb; v.exp_pd = exp_pd;
    v.exp_acc = exp_acc;
    return v;
  endfunction

  // Reference: byte count from size, masks and sign extension by plain arithmetic
  function automatic void ref_model(inout vec_t v);
    longint nb, lim, x;
    bit     timeout;
    if (v.size == 2'b11) begin
      v.exp_rd = 0; v.exp_err = 1'b1; v.exp_stb = 0; v.exp_pd = 0; v.exp_acc = 0;
      return;
    end
    nb        = longint'(1) << v.size;
    lim       = longint'(1) << (8 * nb);
    v.exp_stb = 4'((longint'(1) << nb) - 1);
    v.exp_pd  = 32'(longint'(v.wdata) % lim);
    timeout   = v.never || (v.waits >= int'(TMO));
    v.exp_acc = timeout ? int'(TMO) : v.waits + 1;
    if (timeout || v.perr) begin
      v.exp_rd = 0; v.exp_err = 1'b1;
    end else if (v.wr) begin
      v.exp_rd = 0; v.exp_err = 1'b0;
    end else begin
      x = longint'(v.prd) % lim;
      if (!v.uns && nb < 4 && x >= lim / 2) x = x - lim + (longint'(1) << 32);
      v.exp_rd = 32'(x); v.exp_err = 1'b0;
    end
  endfunction

  task automatic run_txn(input vec_t v);
    int n;
    int acc;
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_addr = v.addr; req_wdata = v.wdata; req_write = v.wr;
    req_size = v.size; req_unsigned = v.uns;
    tick();
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    req_write = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    chk("req_ready_busy", 32'(req_ready), 32'd0);
    if (v.size == 2'b11) begin
      chk("psel_illegal", 32'(psel), 32'd0);
    end else begin
      chk("setup_psel", 32'(psel), 32'd1);
      chk("setup_penable", 32'(penable), 32'd0);
      chk("paddr", paddr, v.addr);
      chk("pdata", pdata, v.exp_pd);
      chk("pstb", 32'(pstb), 32'(v.exp_stb));
      chk("pwrite", 32'(pwrite), 32'(v.wr));
      acc = 0;
      for (int k = 0; k < 40; k++) begin
        tick();
        if (!psel) break;
        acc++;
        chk("access_penable", 32'(penable), 32'd1);
        chk("access_paddr", paddr, v.addr);
        chk("access_pdata", pdata, v.exp_pd);
        chk("access_pstb", 32'(pstb), 32'(v.exp_stb));
        pready = !v.never && (k == v.waits);
        perr   = pready && v.perr;
        prdata = pready ? v.prd : $urandom;
      end
      pready = 1'b0; perr = 1'b0; prdata = $urandom;
      chk("access_cycles", 32'(acc), 32'(v.exp_acc));
      chk("penable_drop", 32'(penable), 32'd0);
    end
    for (int d = 0; d < v.dly; d++) begin
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, v.exp_rd);
      chk("hold_err", 32'(rsp_err), 32'(v.exp_err));
      tick();
    end
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_rdata", rsp_rdata, v.exp_rd);
    chk("rsp_err", 32'(rsp_err), 32'(v.exp_err));
    chk("req_ready_resp", 32'(req_ready), 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_valid_clear", 32'(rsp_valid), 32'd0);
    chk("req_ready_after", 32'(req_ready), 32'd1);
  endtask

  vec_t tbl[12];
  vec_t rv;

  initial begin
    presetn = 1'b0; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_write = 1'b0;
    req_size = '0; req_unsigned = 1'b0; rsp_ready = 1'b0; prdata = '0;
    pready = 1'b0; perr = 1'b0;

    //          addr          wdata         wr   sz     uns  w   prdata        pe   nv   dly rdata         err  stb      pdata         acc
    tbl[0]  = mk(32'h100, 32'hDEADBEEF, 1'b1, 2'b10, 1'b0, 1, 32'h0,        1'b0, 1'b0, 0, 32'h0,        1'b0, 4'b1111, 32'hDEADBEEF, 2);
    tbl[1]  = mk(32'h103, 32'h0,        1'b0, 2'b00, 1'b0, 0, 32'h00000080, 1'b0, 1'b0, 0, 32'hFFFFFF80, 1'b0, 4'b0001, 32'h0,        1);
    tbl[2]  = mk(32'h103, 32'h0,        1'b0, 2'b00, 1'b1, 0, 32'h00000080, 1'b0, 1'b0, 1, 32'h00000080, 1'b0, 4'b0001, 32'h0,        1);
    tbl[3]  = mk(32'h101, 32'hAAAA1234, 1'b1, 2'b01, 1'b0, 2, 32'h0,        1'b0, 1'b0, 0, 32'h0,        1'b0, 4'b0011, 32'h00001234, 3);
    tbl[4]  = mk(32'h200, 32'h0,        1'b0, 2'b10, 1'b0, 0, 32'h0,        1'b0, 1'b1, 0, 32'h0,        1'b1, 4'b1111, 32'h0,        16);
    tbl[5]  = mk(32'h204, 32'h11223344, 1'b1, 2'b11, 1'b0, 0, 32'h0,        1'b0, 1'b0, 5, 32'h0,        1'b1, 4'b0000, 32'h0,        0);
    tbl[6]  = mk(32'h302, 32'h0,        1'b0, 2'b01, 1'b0, 0, 32'h12348001, 1'b0, 1'b0, 0, 32'hFFFF8001, 1'b0, 4'b0011, 32'h0,        1);
    tbl[7]  = mk(32'h302, 32'h0,        1'b0, 2'b01, 1'b1, 1, 32'h12348001, 1'b0, 1'b0, 0, 32'h00008001, 1'b0, 4'b0011, 32'h0,        2);
    tbl[8]  = mk(32'h400, 32'h0,        1'b0, 2'b10, 1'b1, 0, 32'h89ABCDEF, 1'b0, 1'b0, 0, 32'h89ABCDEF, 1'b0, 4'b1111, 32'h0,        1);
    tbl[9]  = mk(32'h404, 32'h0,        1'b0, 2'b00, 1'b1, 1, 32'h00000055, 1'b1, 1'b0, 0, 32'h0,        1'b1, 4'b0001, 32'h0,        2);
    tbl[10] = mk(32'h408, 32'h0,        1'b0, 2'b10, 1'b0, 15, 32'h12345678, 1'b0, 1'b0, 0, 32'h12345678, 1'b0, 4'b1111, 32'h0,       16);
    tbl[11] = mk(32'h003, 32'h123456A5, 1'b1, 2'b00, 1'b0, 0, 32'h0,        1'b0, 1'b0, 2, 32'h0,        1'b0, 4'b0001, 32'h000000A5, 1);

    tick(); tick();
    cur = "reset";
    chk("psel", 32'(psel), 32'd0);
    chk("penable", 32'(penable), 32'd0);
    chk("pwrite", 32'(pwrite), 32'd0);
    chk("paddr", paddr, 32'd0);
    chk("pdata", pdata, 32'd0);
    chk("pstb", 32'(pstb), 32'd0);
    chk("req_ready", 32'(req_ready), 32'd0);
    chk("rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rsp_err", 32'(rsp_err), 32'd0);
    chk("rsp_rdata", rsp_rdata, 32'd0);
    presetn = 1'b1;
    chk("req_ready_at_release", 32'(req_ready), 32'd0);
    tick();
    chk("req_ready_rise", 32'(req_ready), 32'd1);

    for (int i = 0; i < 12; i++) begin
      cur = $sformatf("vec%0d", i);
      run_txn(tbl[i]);
    end

    // Reset pulse during ACCESS: bus drops asynchronously, the request is lost
    cur = "midreset";
    req_valid = 1'b1; req_addr = 32'h500; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    chk("in_access_psel", 32'(psel), 32'd1);
    chk("in_access_penable", 32'(penable), 32'd1);
    #2 presetn = 1'b0;
    #1;
    chk("psel_async", 32'(psel), 32'd0);
    chk("penable_async", 32'(penable), 32'd0);
    chk("rsp_valid_async", 32'(rsp_valid), 32'd0);
    chk("req_ready_async", 32'(req_ready), 32'd0);
    tick();
    presetn = 1'b1;
    pready = 1'b1;
    tick();
    pready = 1'b0;
    chk("req_ready_post", 32'(req_ready), 32'd1);
    chk("rsp_valid_post", 32'(rsp_valid), 32'd0);
    chk("psel_post", 32'(psel), 32'd0);
    tick();
    chk("rsp_valid_post2", 32'(rsp_valid), 32'd0);

    for (int i = 0; i < 40; i++) begin
      cur = $sformatf("rand%0d", i);
      rv.addr  = $urandom;
      rv.wdata = $urandom;
      rv.wr    = 1'($urandom);
      rv.size  = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      rv.uns   = 1'($urandom);
      rv.waits = ($urandom_range(0, 5) == 0) ? int'($urandom_range(13, 18)) : int'($urandom_range(0, 3));
      rv.prd   = $urandom;
      rv.perr  = ($urandom_range(0, 7) == 0);
      rv.never = ($urandom_range(0, 11) == 0);
      rv.dly   = int'($urandom_range(0, 3));
      ref_model(rv);
      run_txn(rv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
